// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch control: run/pause/adjust FSM, BCD minutes/seconds datapath and
// blink mask generation for the seven-segment display mux.
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_SEC     = 59,
  parameter int MAX_MIN     = 59
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       one_hz_clk,
  input  logic       two_hz_clk,
  input  logic       blinky_clk,
  input  logic       pause_btn,
  input  logic       clr_btn,
  input  logic       adj_sw,
  input  logic       sel_sw,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    PAUSED = 2'b01,
    ADJUST = 2'b10
  } state_e;

  state_e state_q, resume_q;

  logic [SYNC_STAGES-1:0] pauseSync_q, clrSync_q, adjSync_q, selSync_q;
  logic pausePrev_q, clrPrev_q, oneHzPrev_q, twoHzPrev_q;
  logic pauseEdge, clrEdge, oneHzTick, twoHzTick, adjOn, selSec;

  logic [3:0] minTens_q, minOnes_q, secTens_q, secOnes_q;
  logic [3:0] minTens_d, minOnes_d, secTens_d, secOnes_d;
  logic [8:0] secInc, minInc;
  logic [3:0] blank_q;

  // Returns {wrap, tens, ones}; anything at or past the terminal value wraps to 00.
  function automatic logic [8:0] bcdInc(input logic [3:0] tens, input logic [3:0] ones,
                                        input int maxVal);
    int value;
    value = int'(tens) * 10 + int'(ones);
    if (value >= maxVal) begin
      return 9'b1_0000_0000;
    end else if (ones >= 4'd9) begin
      return {1'b0, tens + 4'd1, 4'd0};
    end else begin
      return {1'b0, tens, ones + 4'd1};
    end
  endfunction

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      pauseSync_q <= '0;
      clrSync_q   <= '0;
      adjSync_q   <= '0;
      selSync_q   <= '0;
      pausePrev_q <= 1'b0;
      clrPrev_q   <= 1'b0;
      oneHzPrev_q <= 1'b0;
      twoHzPrev_q <= 1'b0;
    end else begin
      pauseSync_q <= {pauseSync_q[SYNC_STAGES-2:0], pause_btn};
      clrSync_q   <= {clrSync_q[SYNC_STAGES-2:0], clr_btn};
      adjSync_q   <= {adjSync_q[SYNC_STAGES-2:0], adj_sw};
      selSync_q   <= {selSync_q[SYNC_STAGES-2:0], sel_sw};
      pausePrev_q <= pauseSync_q[SYNC_STAGES-1];
      clrPrev_q   <= clrSync_q[SYNC_STAGES-1];
      oneHzPrev_q <= one_hz_clk;
      twoHzPrev_q <= two_hz_clk;
    end
  end

  assign pauseEdge = pauseSync_q[SYNC_STAGES-1] & ~pausePrev_q;
  assign clrEdge   = clrSync_q[SYNC_STAGES-1] & ~clrPrev_q;
  assign oneHzTick = one_hz_clk & ~oneHzPrev_q;
  assign twoHzTick = two_hz_clk & ~twoHzPrev_q;
  assign adjOn     = adjSync_q[SYNC_STAGES-1];
  assign selSec    = selSync_q[SYNC_STAGES-1];

  assign secInc = bcdInc(secTens_q, secOnes_q, MAX_SEC);
  assign minInc = bcdInc(minTens_q, minOnes_q, MAX_MIN);

  // Clear has priority over both count and adjust; adjust never carries between fields.
  always_comb begin
    minTens_d = minTens_q;
    minOnes_d = minOnes_q;
    secTens_d = secTens_q;
    secOnes_d = secOnes_q;
    if (clrEdge) begin
      minTens_d = 4'd0;
      minOnes_d = 4'd0;
      secTens_d = 4'd0;
      secOnes_d = 4'd0;
    end else if (state_q == RUN && oneHzTick) begin
      {secTens_d, secOnes_d} = secInc[7:0];
      if (secInc[8]) begin
        {minTens_d, minOnes_d} = minInc[7:0];
      end
    end else if (state_q == ADJUST && twoHzTick) begin
      if (selSec) begin
        {secTens_d, secOnes_d} = secInc[7:0];
      end else begin
        {minTens_d, minOnes_d} = minInc[7:0];
      end
    end
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      minTens_q <= 4'd0;
      minOnes_q <= 4'd0;
      secTens_q <= 4'd0;
      secOnes_q <= 4'd0;
    end else begin
      minTens_q <= minTens_d;
      minOnes_q <= minOnes_d;
      secTens_q <= secTens_d;
      secOnes_q <= secOnes_d;
    end
  end

  // Mode FSM; resume_q remembers where to return when the adjust switch drops.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      resume_q <= RUN;
      blank_q  <= 4'b0000;
    end else begin
      case (state_q)
        RUN: begin
          if (adjOn) begin
            state_q  <= ADJUST;
            resume_q <= RUN;
          end else if (pauseEdge) begin
            state_q <= PAUSED;
          end
        end
        PAUSED: begin
          if (adjOn) begin
            state_q  <= ADJUST;
            resume_q <= PAUSED;
          end else if (pauseEdge) begin
            state_q <= RUN;
          end
        end
        ADJUST: begin
          if (!adjOn) begin
            state_q <= resume_q;
          end
        end
        default: state_q <= RUN;
      endcase

      if (state_q == ADJUST && blinky_clk) begin
        blank_q <= selSec ? 4'b0011 : 4'b1100;
      end else begin
        blank_q <= 4'b0000;
      end
    end
  end

  assign min_tens = minTens_q;
  assign min_ones = minOnes_q;
  assign sec_tens = secTens_q;
  assign sec_ones = secOnes_q;
  assign blank    = blank_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl: expected displays are queued as each
// stimulus step is driven and popped when the resulting outputs are sampled.
module tb_stopwatch_ctrl;

  logic       master_clk;
  logic       rst;
  logic       one_hz_clk, two_hz_clk, blinky_clk;
  logic       pause_btn, clr_btn, adj_sw, sel_sw;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic [1:0] mode;

  typedef struct {
    string       tag;
    logic [21:0] value;
  } exp_t;

  exp_t sbQueue[$];
  int   checks   = 0;
  int   failures = 0;

  stopwatch_ctrl #(.SYNC_STAGES(2), .MAX_SEC(59), .MAX_MIN(59)) dut (
    .master_clk(master_clk),
    .rst       (rst),
    .one_hz_clk(one_hz_clk),
    .two_hz_clk(two_hz_clk),
    .blinky_clk(blinky_clk),
    .pause_btn (pause_btn),
    .clr_btn   (clr_btn),
    .adj_sw    (adj_sw),
    .sel_sw    (sel_sw),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .blank     (blank),
    .mode      (mode)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge master_clk);
    #1;
  endtask

  task automatic pushExpected(input string tag, input logic [1:0] m, input int mm,
                              input int ss, input logic [3:0] b);
    exp_t e;
    e.tag   = tag;
    e.value = {m, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), b};
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [21:0] observed;
    observed = {mode, min_tens, min_ones, sec_tens, sec_ones, blank};
    checks++;
    if (sbQueue.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=<entry>", observed);
    end else begin
      e = sbQueue.pop_front();
      assert (observed === e.value) else begin
        failures++;
        $error("[TB] FAIL %s observed mode=%b time=%h%h:%h%h blank=%b expected mode=%b time=%h%h:%h%h blank=%b",
               e.tag, observed[21:20], observed[19:16], observed[15:12], observed[11:8],
               observed[7:4], observed[3:0], e.value[21:20], e.value[19:16], e.value[15:12],
               e.value[11:8], e.value[7:4], e.value[3:0]);
      end
    end
  endtask

  task automatic applyStimulus(input logic pauseV, input logic clrV, input logic adjV,
                               input logic selV, input logic blinkyV);
    pause_btn  = pauseV;
    clr_btn    = clrV;
    adj_sw     = adjV;
    sel_sw     = selV;
    blinky_clk = blinkyV;
  endtask

  task automatic setAdjust(input logic adjV, input logic selV);
    adj_sw = adjV;
    sel_sw = selV;
    stepCycles(3);
  endtask

  task automatic pressPause();
    pause_btn = 1'b1;
    stepCycles(3);
    pause_btn = 1'b0;
    stepCycles(3);
  endtask

  task automatic oneHzTicks(input int n);
    repeat (n) begin
      one_hz_clk = 1'b1;
      stepCycles(1);
      one_hz_clk = 1'b0;
      stepCycles(1);
    end
  endtask

  task automatic twoHzTicks(input int n);
    repeat (n) begin
      two_hz_clk = 1'b1;
      stepCycles(1);
      two_hz_clk = 1'b0;
      stepCycles(1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    one_hz_clk = 1'b0;
    two_hz_clk = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(2);
    rst = 1'b0;
    stepCycles(1);
    pushExpected("reset_state", 2'b00, 0, 0, 4'b0000);
    checkOutput();

    // Preload via adjust, then minute carry and full wrap.
    pushExpected("adj_enter", 2'b10, 0, 0, 4'b0000);
    setAdjust(1'b1, 1'b0);
    checkOutput();
    pushExpected("blank_min", 2'b10, 0, 0, 4'b1100);
    blinky_clk = 1'b1;
    stepCycles(1);
    checkOutput();
    pushExpected("blank_off", 2'b10, 0, 0, 4'b0000);
    blinky_clk = 1'b0;
    stepCycles(1);
    checkOutput();
    pushExpected("preload_0059", 2'b10, 0, 59, 4'b0000);
    setAdjust(1'b1, 1'b1);
    twoHzTicks(59);
    checkOutput();
    pushExpected("run_0059", 2'b00, 0, 59, 4'b0000);
    setAdjust(1'b0, 1'b1);
    checkOutput();
    pushExpected("carry_0100", 2'b00, 1, 0, 4'b0000);
    oneHzTicks(1);
    checkOutput();
    pushExpected("preload_5959", 2'b10, 59, 59, 4'b0000);
    setAdjust(1'b1, 1'b0);
    twoHzTicks(58);
    setAdjust(1'b1, 1'b1);
    twoHzTicks(59);
    checkOutput();
    pushExpected("run_5959", 2'b00, 59, 59, 4'b0000);
    setAdjust(1'b0, 1'b1);
    checkOutput();
    pushExpected("wrap_0000", 2'b00, 0, 0, 4'b0000);
    oneHzTicks(1);
    checkOutput();

    // Pause latency and hold, then resume.
    pushExpected("count_0002", 2'b00, 0, 2, 4'b0000);
    oneHzTicks(2);
    checkOutput();
    pushExpected("pause_2edges", 2'b00, 0, 2, 4'b0000);
    pause_btn = 1'b1;
    stepCycles(2);
    checkOutput();
    pushExpected("pause_3edges", 2'b01, 0, 2, 4'b0000);
    stepCycles(1);
    checkOutput();
    pause_btn = 1'b0;
    stepCycles(3);
    pushExpected("paused_hold", 2'b01, 0, 2, 4'b0000);
    oneHzTicks(5);
    checkOutput();
    pushExpected("resume", 2'b00, 0, 2, 4'b0000);
    pressPause();
    checkOutput();
    pushExpected("resume_count", 2'b00, 0, 3, 4'b0000);
    oneHzTicks(1);
    checkOutput();

    // Adjust seconds from PAUSED at 00:58, field wrap without carry.
    pushExpected("run_0058", 2'b00, 0, 58, 4'b0000);
    setAdjust(1'b1, 1'b1);
    twoHzTicks(55);
    setAdjust(1'b0, 1'b1);
    checkOutput();
    pushExpected("paused_0058", 2'b01, 0, 58, 4'b0000);
    pressPause();
    checkOutput();
    pushExpected("adj_from_paused", 2'b10, 0, 58, 4'b0000);
    setAdjust(1'b1, 1'b1);
    checkOutput();
    pushExpected("adj_sec_wrap", 2'b10, 0, 1, 4'b0000);
    twoHzTicks(3);
    checkOutput();
    pushExpected("blank_sec", 2'b10, 0, 1, 4'b0011);
    blinky_clk = 1'b1;
    stepCycles(1);
    checkOutput();
    blinky_clk = 1'b0;
    stepCycles(1);
    pushExpected("adj_ignore_pause", 2'b10, 0, 1, 4'b0000);
    pressPause();
    checkOutput();
    pushExpected("blank_retarget", 2'b10, 0, 1, 4'b1100);
    setAdjust(1'b1, 1'b0);
    blinky_clk = 1'b1;
    stepCycles(1);
    checkOutput();
    blinky_clk = 1'b0;
    stepCycles(1);
    pushExpected("adj_min", 2'b10, 1, 1, 4'b0000);
    twoHzTicks(1);
    checkOutput();
    pushExpected("resume_paused", 2'b01, 1, 1, 4'b0000);
    setAdjust(1'b0, 1'b0);
    checkOutput();

    // Clear coincident with a count tick at 07:07.
    pushExpected("run_0707", 2'b00, 7, 7, 4'b0000);
    setAdjust(1'b1, 1'b0);
    twoHzTicks(6);
    setAdjust(1'b1, 1'b1);
    twoHzTicks(6);
    setAdjust(1'b0, 1'b1);
    pressPause();
    checkOutput();
    pushExpected("clr_beats_tick", 2'b00, 0, 0, 4'b0000);
    clr_btn = 1'b1;
    stepCycles(2);
    one_hz_clk = 1'b1;
    stepCycles(1);
    checkOutput();
    one_hz_clk = 1'b0;
    clr_btn    = 1'b0;
    stepCycles(3);

    // Pause edge and count tick in the same RUN cycle.
    pushExpected("run_0010", 2'b00, 0, 10, 4'b0000);
    oneHzTicks(10);
    checkOutput();
    pushExpected("pause_and_tick", 2'b01, 0, 11, 4'b0000);
    pause_btn = 1'b1;
    stepCycles(2);
    one_hz_clk = 1'b1;
    stepCycles(1);
    checkOutput();
    one_hz_clk = 1'b0;
    pause_btn  = 1'b0;
    stepCycles(3);

    // Asynchronous reset while running at 12:34.
    pushExpected("run_1234", 2'b00, 12, 34, 4'b0000);
    pressPause();
    setAdjust(1'b1, 1'b0);
    twoHzTicks(12);
    setAdjust(1'b1, 1'b1);
    twoHzTicks(23);
    setAdjust(1'b0, 1'b1);
    checkOutput();
    pushExpected("async_reset", 2'b00, 0, 0, 4'b0000);
    rst = 1'b1;
    #2;
    checkOutput();
    stepCycles(1);
    rst = 1'b0;
    pushExpected("post_reset_count", 2'b00, 0, 1, 4'b0000);
    oneHzTicks(1);
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
